// File: rtl/universal_shift_register_if.sv
// -----------------------------------------------------------------------------
// universal_shift_register_if
//
// Purpose:
//   Groups the command/handshake bus of universal_shift_register into one
//   bundle. Signal names keep the block's documented port names.
//
// Signals:
//   data_i      [WIDTH] parallel load value
//   mode_i      [3]     operation select, sampled on accept
//   amt_i       [AMT_W] number of single-bit steps, sampled on accept
//   start_i             command request, accepted only while busy_o = 0
//   ser_l_i             serial fill into MSB for logical shift right
//   ser_r_i             serial fill into LSB for shift left
//   Y_o         [WIDTH] register contents
//   busy_o              command in progress
//   done_o              one-cycle pulse on command completion
//   shift_out_o         last bit shifted or rotated out
//   abort_i / aborted_o only when USR_ABORT_EN is defined
//
// Handshake: the controller raises start_i while busy_o = 0. The command is
//   accepted on that rising edge, busy_o rises in the next cycle and stays
//   high until the single done_o cycle has passed. start_i seen while
//   busy_o = 1 is dropped, not queued.
//
// Modports:
//   master - controller side (drives commands, observes status)
//   slave  - shift register side
//
// Configuration macro: USR_ABORT_EN
// -----------------------------------------------------------------------------
interface universal_shift_register_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic [WIDTH-1:0] data_i;
  logic [2:0]       mode_i;
  logic [AMT_W-1:0] amt_i;
  logic             start_i;
  logic             ser_l_i;
  logic             ser_r_i;
  logic [WIDTH-1:0] Y_o;
  logic             busy_o;
  logic             done_o;
  logic             shift_out_o;
`ifdef USR_ABORT_EN
  logic             abort_i;
  logic             aborted_o;
`endif

`ifdef USR_ABORT_EN
  modport master (
    output data_i, mode_i, amt_i, start_i, ser_l_i, ser_r_i, abort_i,
    input  Y_o, busy_o, done_o, shift_out_o, aborted_o
  );

  modport slave (
    input  data_i, mode_i, amt_i, start_i, ser_l_i, ser_r_i, abort_i,
    output Y_o, busy_o, done_o, shift_out_o, aborted_o
  );
`else
  modport master (
    output data_i, mode_i, amt_i, start_i, ser_l_i, ser_r_i,
    input  Y_o, busy_o, done_o, shift_out_o
  );

  modport slave (
    input  data_i, mode_i, amt_i, start_i, ser_l_i, ser_r_i,
    output Y_o, busy_o, done_o, shift_out_o
  );
`endif

endinterface

// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
//
// Purpose:
//   Parametrised universal shift register with parallel load. One command is
//   accepted per start pulse: a parallel load, a hold, or a shift/rotate of
//   amt_i single-bit steps executed one step per clock.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      universal_shift_register_if.slave (command + status bundle)
//   o_state  current FSM state (IDLE=0, RUN=1, DONE=2) for observation
//
// Modes (mode_i):
//   000 hold, 001 load, 010 shift left, 011 logical shift right,
//   100 rotate left, 101 rotate right, 110 arithmetic shift right,
//   111 reserved (behaves as hold)
//
// Timing:
//   The first step of a shift/rotate happens on the accept edge itself, so an
//   N-step command spends N-1 cycles in RUN plus one DONE cycle: busy_o is
//   high for N cycles and done_o marks the cycle in which the result is valid.
//   Load/hold/reserved and N = 0 go straight to DONE (busy_o for one cycle).
//
// Configuration macro: USR_ABORT_EN
//   When defined, abort_i in RUN ends the command early on that edge without
//   stepping; aborted_o accompanies the done_o pulse.
// -----------------------------------------------------------------------------
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  universal_shift_register_if.slave   bus,
  output logic [1:0]                  o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;

  localparam logic [AMT_W-1:0] AMT_ZERO = '0;
  localparam logic [AMT_W-1:0] AMT_ONE  = AMT_W'(1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH-1:0] r_y;
  logic             r_out;
  logic [2:0]       r_mode;
  logic [AMT_W-1:0] r_rem;
`ifdef USR_ABORT_EN
  logic             r_aborted;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / next-data wires
  // ---------------------------------------------------------------------------
  state_t           w_nxt_state;
  logic [WIDTH-1:0] w_nxt_y;
  logic             w_nxt_out;
  logic [2:0]       w_nxt_mode;
  logic [AMT_W-1:0] w_nxt_rem;
`ifdef USR_ABORT_EN
  logic             w_nxt_aborted;
`endif

  logic [2:0]       w_op_mode;
  logic [WIDTH-1:0] w_step_y;
  logic             w_step_out;
  logic             w_abort;

`ifdef USR_ABORT_EN
  assign w_abort = bus.abort_i;
`else
  assign w_abort = 1'b0;
`endif

  // On the accept edge the latched mode is not yet valid, so the step logic
  // looks at mode_i directly; in RUN it uses the latched copy.
  assign w_op_mode = (r_state == S_IDLE) ? bus.mode_i : r_mode;

  // ---------------------------------------------------------------------------
  // Single-bit step. Serial fills are taken live on every step edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_step_y   = r_y;
    w_step_out = r_out;
    case (w_op_mode)
      M_SHL: begin
        w_step_y   = {r_y[WIDTH-2:0], bus.ser_r_i};
        w_step_out = r_y[WIDTH-1];
      end
      M_SHR: begin
        w_step_y   = {bus.ser_l_i, r_y[WIDTH-1:1]};
        w_step_out = r_y[0];
      end
      M_ROL: begin
        w_step_y   = {r_y[WIDTH-2:0], r_y[WIDTH-1]};
        w_step_out = r_y[WIDTH-1];
      end
      M_ROR: begin
        w_step_y   = {r_y[0], r_y[WIDTH-1:1]};
        w_step_out = r_y[0];
      end
      M_ASR: begin
        w_step_y   = {r_y[WIDTH-1], r_y[WIDTH-1:1]};
        w_step_out = r_y[0];
      end
      default: begin
        w_step_y   = r_y;
        w_step_out = r_out;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_y       = r_y;
    w_nxt_out     = r_out;
    w_nxt_mode    = r_mode;
    w_nxt_rem     = r_rem;
`ifdef USR_ABORT_EN
    w_nxt_aborted = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_nxt_mode = bus.mode_i;
          w_nxt_rem  = AMT_ZERO;
          case (bus.mode_i)
            M_LOAD: begin
              w_nxt_y     = bus.data_i;
              w_nxt_state = S_DONE;
            end
            M_SHL, M_SHR, M_ROL, M_ROR, M_ASR: begin
              if (bus.amt_i == AMT_ZERO) begin
                w_nxt_state = S_DONE;
              end else begin
                // First step happens right here on the accept edge.
                w_nxt_y     = w_step_y;
                w_nxt_out   = w_step_out;
                w_nxt_rem   = bus.amt_i - AMT_ONE;
                w_nxt_state = (bus.amt_i == AMT_ONE) ? S_DONE : S_RUN;
              end
            end
            default: begin
              // hold and reserved: nothing to do, just report completion
              w_nxt_state = S_DONE;
            end
          endcase
        end
      end

      S_RUN: begin
        if (w_abort) begin
          w_nxt_state   = S_DONE;
`ifdef USR_ABORT_EN
          w_nxt_aborted = 1'b1;
`endif
        end else begin
          w_nxt_y     = w_step_y;
          w_nxt_out   = w_step_out;
          w_nxt_rem   = r_rem - AMT_ONE;
          // rem is about to reach zero: this was the last step
          if (r_rem == AMT_ONE) begin
            w_nxt_state = S_DONE;
          end
        end
      end

      S_DONE: begin
        w_nxt_state = S_IDLE;
      end

      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_y       <= '0;
      r_out     <= 1'b0;
      r_mode    <= M_HOLD;
      r_rem     <= AMT_ZERO;
`ifdef USR_ABORT_EN
      r_aborted <= 1'b0;
`endif
    end else begin
      r_state   <= w_nxt_state;
      r_y       <= w_nxt_y;
      r_out     <= w_nxt_out;
      r_mode    <= w_nxt_mode;
      r_rem     <= w_nxt_rem;
`ifdef USR_ABORT_EN
      r_aborted <= w_nxt_aborted;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all decoded from registers, so reset clears them immediately.
  // ---------------------------------------------------------------------------
  assign bus.Y_o         = r_y;
  assign bus.busy_o      = (r_state != S_IDLE);
  assign bus.done_o      = (r_state == S_DONE);
  assign bus.shift_out_o = r_out;
`ifdef USR_ABORT_EN
  assign bus.aborted_o   = r_aborted;
`endif
  assign o_state         = r_state;

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

  localparam int W     = 8;
  localparam int AMT_W = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  universal_shift_register_if #(.WIDTH(W), .AMT_W(AMT_W)) bus ();

  universal_shift_register #(.WIDTH(W), .AMT_W(AMT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Issues one command and waits until the block returns to idle. Returns the
  // number of sampled cycles with busy_o high and with done_o high.
  task automatic run_cmd(input logic [2:0] m, input logic [AMT_W-1:0] a,
                         input logic [W-1:0] d, input logic sl, input logic sr,
                         output int busy_n, output int done_n);
    @(negedge clk);
    bus.mode_i  = m;
    bus.amt_i   = a;
    bus.data_i  = d;
    bus.ser_l_i = sl;
    bus.ser_r_i = sr;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    busy_n = 0;
    done_n = 0;
    for (int k = 0; k < 64 && bus.busy_o; k++) begin
      busy_n++;
      if (bus.done_o) done_n++;
      @(negedge clk);
    end
  endtask

  task automatic load(input logic [W-1:0] d);
    int b, dn;
    run_cmd(3'b001, '0, d, 1'b0, 1'b0, b, dn);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [2:0]       mode;
    logic [AMT_W-1:0] amt;
    logic [W-1:0]     data;
    logic             sl;
    logic             sr;
    logic [W-1:0]     exp_y;
    logic             exp_out;
    int               exp_busy;
  } vec_t;

  vec_t vecs[18];

  initial begin
    int busy_n, done_n;
    logic [W-1:0] exp_y;
    logic fill[4];

    vecs[0]  = '{3'b001, 4'd0,  8'h96, 1'b0, 1'b0, 8'h96, 1'b0, 1};  // load
    vecs[1]  = '{3'b100, 4'd3,  8'h00, 1'b0, 1'b0, 8'hB4, 1'b0, 3};  // rol 3
    vecs[2]  = '{3'b101, 4'd1,  8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 1};  // ror 1
    vecs[3]  = '{3'b001, 4'd7,  8'hF0, 1'b0, 1'b0, 8'hF0, 1'b0, 1};  // load, amt ignored
    vecs[4]  = '{3'b010, 4'd2,  8'h00, 1'b0, 1'b1, 8'hC3, 1'b1, 2};  // shl 2 fill 1
    vecs[5]  = '{3'b000, 4'd5,  8'hFF, 1'b1, 1'b1, 8'hC3, 1'b1, 1};  // hold
    vecs[6]  = '{3'b111, 4'd3,  8'h5A, 1'b1, 1'b1, 8'hC3, 1'b1, 1};  // reserved
    vecs[7]  = '{3'b100, 4'd8,  8'h00, 1'b0, 1'b0, 8'hC3, 1'b1, 8};  // rol WIDTH
    vecs[8]  = '{3'b101, 4'd9,  8'h00, 1'b0, 1'b0, 8'hE1, 1'b1, 9};  // ror 9 wraps
    vecs[9]  = '{3'b011, 4'd15, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 15}; // shr saturate
    vecs[10] = '{3'b001, 4'd0,  8'h80, 1'b0, 1'b0, 8'h80, 1'b0, 1};  // load
    vecs[11] = '{3'b110, 4'd15, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 15}; // asr saturate
    vecs[12] = '{3'b010, 4'd0,  8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 1};  // shl amt 0
    vecs[13] = '{3'b001, 4'd0,  8'h35, 1'b0, 1'b0, 8'h35, 1'b1, 1};  // load, out held
    vecs[14] = '{3'b010, 4'd10, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 10}; // shl saturate
    vecs[15] = '{3'b011, 4'd1,  8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1};  // shr fill 1
    vecs[16] = '{3'b001, 4'd0,  8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1};  // load
    vecs[17] = '{3'b110, 4'd1,  8'h00, 1'b0, 1'b0, 8'hC0, 1'b1, 1};  // asr 1

    // -------------------------------------------------------------------------
    // Reset
    // -------------------------------------------------------------------------
    rst_n       = 1'b0;
    bus.data_i  = '0;
    bus.mode_i  = '0;
    bus.amt_i   = '0;
    bus.start_i = 1'b0;
    bus.ser_l_i = 1'b0;
    bus.ser_r_i = 1'b0;
`ifdef USR_ABORT_EN
    bus.abort_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_y",     32'(bus.Y_o),         32'h0);
    chk("reset_busy",  32'(bus.busy_o),      32'h0);
    chk("reset_done",  32'(bus.done_o),      32'h0);
    chk("reset_out",   32'(bus.shift_out_o), 32'h0);
    chk("reset_state", 32'(dbg_state),       32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // -------------------------------------------------------------------------
    // Table-driven vectors
    // -------------------------------------------------------------------------
    for (int i = 0; i < 18; i++) begin
      exp_q.push_back(vecs[i].exp_y);
      run_cmd(vecs[i].mode, vecs[i].amt, vecs[i].data, vecs[i].sl, vecs[i].sr,
              busy_n, done_n);
      exp_y = exp_q.pop_front();
      chk($sformatf("vec%0d_y", i),    32'(bus.Y_o),         32'(exp_y));
      chk($sformatf("vec%0d_out", i),  32'(bus.shift_out_o), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_busy", i), 32'(busy_n),          32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_done", i), 32'(done_n),          32'd1);
    end

    // -------------------------------------------------------------------------
    // Logical shift right with a live serial fill changing every step
    // -------------------------------------------------------------------------
    load(8'hF0);
    fill[0] = 1'b1; fill[1] = 1'b0; fill[2] = 1'b1; fill[3] = 1'b0;
    @(negedge clk);
    bus.mode_i  = 3'b011;
    bus.amt_i   = 4'd4;
    bus.ser_l_i = fill[0];
    bus.start_i = 1'b1;
    for (int s = 1; s < 4; s++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.ser_l_i = fill[s];
    end
    @(negedge clk);
    chk("livefill_done", 32'(bus.done_o),      32'h1);
    chk("livefill_y",    32'(bus.Y_o),         32'h5F);
    chk("livefill_out",  32'(bus.shift_out_o), 32'h0);
    @(negedge clk);

    // -------------------------------------------------------------------------
    // start_i held high: one command per busy window, re-accept only after idle
    // -------------------------------------------------------------------------
    load(8'h01);
    @(negedge clk);
    bus.mode_i  = 3'b010;
    bus.amt_i   = 4'd5;
    bus.ser_r_i = 1'b0;
    bus.start_i = 1'b1;
    @(negedge clk);
    busy_n = 0;
    done_n = 0;
    for (int k = 0; k < 64 && bus.busy_o; k++) begin
      busy_n++;
      if (bus.done_o) done_n++;
      @(negedge clk);
    end
    chk("held_busy", 32'(busy_n),  32'd5);
    chk("held_done", 32'(done_n),  32'd1);
    chk("held_y",    32'(bus.Y_o), 32'h20);
    // start is still high while idle: the next edge accepts a second command
    @(negedge clk);
    chk("held_reaccept", 32'(bus.busy_o), 32'h1);
    bus.start_i = 1'b0;
    for (int k = 0; k < 64 && bus.busy_o; k++) @(negedge clk);
    chk("held_second_y", 32'(bus.Y_o), 32'h00);

    // -------------------------------------------------------------------------
    // Asynchronous reset in the middle of a rotate
    // -------------------------------------------------------------------------
    load(8'hAA);
    @(negedge clk);
    bus.mode_i  = 3'b100;
    bus.amt_i   = 4'd10;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrun_busy", 32'(bus.busy_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_y",    32'(bus.Y_o),         32'h0);
    chk("arst_busy", 32'(bus.busy_o),      32'h0);
    chk("arst_done", 32'(bus.done_o),      32'h0);
    chk("arst_out",  32'(bus.shift_out_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_no_resume", 32'(bus.busy_o), 32'h0);

`ifdef USR_ABORT_EN
    // -------------------------------------------------------------------------
    // Abort on the third RUN cycle keeps the partial result
    // -------------------------------------------------------------------------
    load(8'h01);
    @(negedge clk);
    bus.mode_i  = 3'b010;
    bus.amt_i   = 4'd6;
    bus.ser_r_i = 1'b0;
    bus.start_i = 1'b1;
    bus.abort_i = 1'b1;          // ignored on the accept edge
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.abort_i = 1'b1;
    @(negedge clk);
    bus.abort_i = 1'b0;
    chk("abort_done",    32'(bus.done_o),    32'h1);
    chk("abort_flag",    32'(bus.aborted_o), 32'h1);
    chk("abort_y",       32'(bus.Y_o),       32'h08);
    @(negedge clk);
    chk("abort_idle",    32'(bus.busy_o),    32'h0);
    chk("abort_cleared", 32'(bus.aborted_o), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
